core_lsu: RTL and testbench
===========================

Name: core_lsu

Overview:
Load/store unit between the execute stage and the core memory arbiter's LSU read/write ports. Takes one memory instruction at a time and computes the effective address. Checks alignment and funct3, then issues a word-aligned read or a posted byte-enabled write to the arbiter. Load data is lane-extracted and sign/zero-extended for writeback; failures are reported with a cause code and the faulting address.

Parameters:
AW, 32, address width
DW, 32, data width (fixed 32; other values unsupported)
TIMEOUT_CYCLES, 255, max cycles in LOAD_REQ waiting for i_mem_ack before bus-timeout fault (1..65535)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  synchronous active-low reset
i_clk_en  in  1  global clock enable; all state frozen when low
i_valid  in  1  memory instruction present (sampled only when o_busy=0)
i_is_load  in  1  instruction is a load
i_is_store  in  1  instruction is a store
i_funct3  in  3  RV32I width/sign code
i_base  in  AW  rs1 value
i_offset  in  AW  sign-extended immediate
i_store_data  in  DW  rs2 value
i_rd  in  5  load destination register
o_busy  out  1  high while state != IDLE
o_mem_read  out  1  read request to arbiter LSU port
o_mem_read_addr  out  AW  word-aligned read address
i_mem_read_data  in  DW  arbiter read data
i_mem_ack  in  1  arbiter read acknowledge (data valid same cycle)
o_mem_write  out  1  one-cycle posted write strobe
o_mem_write_addr  out  AW  word-aligned write address
o_mem_byte_en  out  4  write byte lanes
o_mem_write_data  out  DW  lane-replicated write data
o_wb_valid  out  1  one-cycle load result pulse
o_wb_rd  out  5  load destination
o_wb_data  out  DW  extended load result
o_exc  out  1  one-cycle fault pulse
o_exc_cause  out  3  1 load misaligned, 2 store misaligned, 3 illegal, 4 bus timeout
o_exc_addr  out  AW  faulting effective address

Behaviour:
- Reset (i_rst_n=0 at edge): state IDLE; all outputs 0; timeout counter 0. Reset mid-load abandons the request; a late i_mem_ack in IDLE is ignored.
- i_clk_en=0: no state, counter or output register changes.
- States: IDLE, LOAD_REQ, STORE, RESP.
- Accept: IDLE & i_valid & (i_is_load|i_is_store). Register ea = (i_base+i_offset) mod 2^AW, plus funct3, rd and store data.
- Illegal: both is_load and is_store high, load funct3 not in {0,1,2,4,5}, or store funct3 not in {0,1,2}. -> RESP, cause 3, no memory access.
- Misaligned: halfword with ea[0]=1, or word with ea[1:0]!=0. -> RESP, cause 1 (load) or 2 (store), no memory access.
- Load -> LOAD_REQ:
  - o_mem_read=1 and o_mem_read_addr={ea[AW-1:2],2'b00}, both held until i_mem_ack.
  - Counter increments each enabled cycle in LOAD_REQ.
  - On ack: capture data, go to RESP.
  - If counter reaches TIMEOUT_CYCLES without ack: drop o_mem_read and go to RESP with cause 4. Ack in the same cycle as the timeout wins.
- Load extraction: byte = data[8*ea[1:0]+:8], half = data[16*ea[1]+:16]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word. rd=0 gives o_wb_data=0.
- Store -> STORE, a single cycle:
  - o_mem_write=1; o_mem_write_addr word-aligned.
  - Byte enables: SB 4'b0001<<ea[1:0], SH 4'b0011<<{ea[1],1'b0}, SW 4'b1111.
  - Data: SB {4{b}}, SH {2{h}}, SW word.
  - Then IDLE; no writeback, no ack expected.
- RESP, one cycle: either o_wb_valid=1 with rd/data, or o_exc=1 with cause/addr (never both); then IDLE.
- Pulse outputs return to 0 on the next enabled cycle; data/address outputs hold their last value.
- Latency: load with immediate ack gives o_wb_valid 2 cycles after accept. Store write strobe is 1 cycle after accept. Fault pulse is 1 cycle after accept (timeout: TIMEOUT_CYCLES+1).
- Throughput: next accept possible in the cycle the state returns to IDLE.
- Effective address wraps modulo 2^AW with no fault.

Test Plan:
- LB, base=0x100, off=3, mem word 0x80FF_1234 at 0x100, ack 1 cycle after request -> read_addr 0x100, o_wb_data 0xFFFF_FF80, o_wb_valid 3 cycles after accept; LBU same -> 0x0000_0080.
- SH, base=0x202, off=0, data 0x0000_ABCD -> one-cycle o_mem_write, addr 0x200, byte_en 4'b1100, wdata 0xABCD_ABCD, o_busy high exactly 1 cycle.
- LW at ea 0x102 -> no o_mem_read, o_exc cause 1, o_exc_addr 0x102 one cycle after accept; store funct3=3 -> cause 3.
- Load, no ack, TIMEOUT_CYCLES=4 -> o_mem_read high 4 cycles, then o_exc cause 4; ack on the 4th cycle -> o_wb_valid instead.
- Reset asserted during LOAD_REQ, ack arrives the cycle after -> all outputs 0, no o_wb_valid, next load completes normally.
- i_clk_en low 3 cycles mid-LOAD_REQ with ack held off -> counter and o_mem_read frozen; base=0xFFFF_FFFC, off=8 -> read_addr 0x0000_0004.

Source files
------------

// File: rtl/core_lsu.sv
// Load/store unit: computes the effective address, validates width and alignment,
// issues a word read or a posted byte-enabled write, and returns extended load data or a fault.
module core_lsu #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clk_en,
  input  logic          i_valid,
  input  logic          i_is_load,
  input  logic          i_is_store,
  input  logic [2:0]    i_funct3,
  input  logic [AW-1:0] i_base,
  input  logic [AW-1:0] i_offset,
  input  logic [DW-1:0] i_store_data,
  input  logic [4:0]    i_rd,
  output logic          o_busy,
  output logic          o_mem_read,
  output logic [AW-1:0] o_mem_read_addr,
  input  logic [DW-1:0] i_mem_read_data,
  input  logic          i_mem_ack,
  output logic          o_mem_write,
  output logic [AW-1:0] o_mem_write_addr,
  output logic [3:0]    o_mem_byte_en,
  output logic [DW-1:0] o_mem_write_data,
  output logic          o_wb_valid,
  output logic [4:0]    o_wb_rd,
  output logic [DW-1:0] o_wb_data,
  output logic          o_exc,
  output logic [2:0]    o_exc_cause,
  output logic [AW-1:0] o_exc_addr
);

  typedef enum logic [1:0] {IDLE, LOAD_REQ, STORE, RESP} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t        state_reg, state_next;
  logic [AW-1:0] ea_reg, ea_next;
  logic [2:0]    funct3_reg, funct3_next;
  logic [4:0]    rd_reg, rd_next;
  logic [15:0]   cnt_reg, cnt_next;

  logic          mem_read_reg, mem_read_next;
  logic [AW-1:0] read_addr_reg, read_addr_next;
  logic          mem_write_reg, mem_write_next;
  logic [AW-1:0] write_addr_reg, write_addr_next;
  logic [3:0]    byte_en_reg, byte_en_next;
  logic [DW-1:0] write_data_reg, write_data_next;
  logic          wb_valid_reg, wb_valid_next;
  logic [4:0]    wb_rd_reg, wb_rd_next;
  logic [DW-1:0] wb_data_reg, wb_data_next;
  logic          exc_reg, exc_next;
  logic [2:0]    exc_cause_reg, exc_cause_next;
  logic [AW-1:0] exc_addr_reg, exc_addr_next;

  logic [AW-1:0] ea_in;
  logic          accept, load_f3_ok, store_f3_ok, illegal, misaligned, timeout_hit;
  logic [3:0]    st_be;
  logic [DW-1:0] st_data;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [DW-1:0] ld_ext;

  assign ea_in       = i_base + i_offset;
  assign accept      = (state_reg == IDLE) && i_valid && (i_is_load || i_is_store);
  assign load_f3_ok  = i_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  assign store_f3_ok = i_funct3 inside {3'd0, 3'd1, 3'd2};
  assign illegal     = (i_is_load && i_is_store) || (i_is_load && !load_f3_ok) ||
                       (i_is_store && !store_f3_ok);
  assign misaligned  = ((i_funct3[1:0] == 2'b01) && ea_in[0]) ||
                       ((i_funct3[1:0] == 2'b10) && (ea_in[1:0] != 2'b00));
  assign timeout_hit = (cnt_reg == TO_LAST);

  // Per-lane store steering: each byte lane picks its enable and source byte from the access size.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign st_be[gi] = (i_funct3[1:0] == 2'b00) ? (ea_in[1:0] == 2'(gi)) :
                       (i_funct3[1:0] == 2'b01) ? (ea_in[1] == 1'(gi / 2)) : 1'b1;
    assign st_data[8*gi +: 8] = (i_funct3[1:0] == 2'b00) ? i_store_data[7:0] :
                                (i_funct3[1:0] == 2'b01) ? i_store_data[8*(gi % 2) +: 8] :
                                i_store_data[8*gi +: 8];
  end

  assign ld_byte = i_mem_read_data[{ea_reg[1:0], 3'b000} +: 8];
  assign ld_half = i_mem_read_data[{ea_reg[1], 4'b0000} +: 16];

  always_comb begin
    case (funct3_reg)
      3'd0:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    ld_ext = {{16{ld_half[15]}}, ld_half};
      3'd4:    ld_ext = {24'h0, ld_byte};
      3'd5:    ld_ext = {16'h0, ld_half};
      default: ld_ext = i_mem_read_data;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)      state_reg <= IDLE;
    else if (i_clk_en) state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (illegal || misaligned) state_next = RESP;
          else if (i_is_load)        state_next = LOAD_REQ;
          else                       state_next = STORE;
        end
      end
      LOAD_REQ: if (i_mem_ack || timeout_hit) state_next = RESP;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    ea_next         = ea_reg;
    funct3_next     = funct3_reg;
    rd_next         = rd_reg;
    cnt_next        = '0;
    mem_read_next   = 1'b0;
    read_addr_next  = read_addr_reg;
    mem_write_next  = 1'b0;
    write_addr_next = write_addr_reg;
    byte_en_next    = byte_en_reg;
    write_data_next = write_data_reg;
    wb_valid_next   = 1'b0;
    wb_rd_next      = wb_rd_reg;
    wb_data_next    = wb_data_reg;
    exc_next        = 1'b0;
    exc_cause_next  = exc_cause_reg;
    exc_addr_next   = exc_addr_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          ea_next     = ea_in;
          funct3_next = i_funct3;
          rd_next     = i_rd;
          if (illegal) begin
            exc_next       = 1'b1;
            exc_cause_next = 3'd3;
            exc_addr_next  = ea_in;
          end else if (misaligned) begin
            exc_next       = 1'b1;
            exc_cause_next = i_is_load ? 3'd1 : 3'd2;
            exc_addr_next  = ea_in;
          end else if (i_is_load) begin
            mem_read_next  = 1'b1;
            read_addr_next = {ea_in[AW-1:2], 2'b00};
          end else begin
            mem_write_next  = 1'b1;
            write_addr_next = {ea_in[AW-1:2], 2'b00};
            byte_en_next    = st_be;
            write_data_next = st_data;
          end
        end
      end
      LOAD_REQ: begin
        // An ack arriving in the final allowed cycle still completes the load.
        if (i_mem_ack) begin
          wb_valid_next = 1'b1;
          wb_rd_next    = rd_reg;
          wb_data_next  = (rd_reg == 5'd0) ? '0 : ld_ext;
        end else if (timeout_hit) begin
          exc_next       = 1'b1;
          exc_cause_next = 3'd4;
          exc_addr_next  = ea_reg;
        end else begin
          mem_read_next = 1'b1;
          cnt_next      = cnt_reg + 16'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ea_reg         <= '0;
      funct3_reg     <= '0;
      rd_reg         <= '0;
      cnt_reg        <= '0;
      mem_read_reg   <= 1'b0;
      read_addr_reg  <= '0;
      mem_write_reg  <= 1'b0;
      write_addr_reg <= '0;
      byte_en_reg    <= '0;
      write_data_reg <= '0;
      wb_valid_reg   <= 1'b0;
      wb_rd_reg      <= '0;
      wb_data_reg    <= '0;
      exc_reg        <= 1'b0;
      exc_cause_reg  <= '0;
      exc_addr_reg   <= '0;
    end else if (i_clk_en) begin
      ea_reg         <= ea_next;
      funct3_reg     <= funct3_next;
      rd_reg         <= rd_next;
      cnt_reg        <= cnt_next;
      mem_read_reg   <= mem_read_next;
      read_addr_reg  <= read_addr_next;
      mem_write_reg  <= mem_write_next;
      write_addr_reg <= write_addr_next;
      byte_en_reg    <= byte_en_next;
      write_data_reg <= write_data_next;
      wb_valid_reg   <= wb_valid_next;
      wb_rd_reg      <= wb_rd_next;
      wb_data_reg    <= wb_data_next;
      exc_reg        <= exc_next;
      exc_cause_reg  <= exc_cause_next;
      exc_addr_reg   <= exc_addr_next;
    end
  end

  assign o_busy           = (state_reg != IDLE);
  assign o_mem_read       = mem_read_reg;
  assign o_mem_read_addr  = read_addr_reg;
  assign o_mem_write      = mem_write_reg;
  assign o_mem_write_addr = write_addr_reg;
  assign o_mem_byte_en    = byte_en_reg;
  assign o_mem_write_data = write_data_reg;
  assign o_wb_valid       = wb_valid_reg;
  assign o_wb_rd          = wb_rd_reg;
  assign o_wb_data        = wb_data_reg;
  assign o_exc            = exc_reg;
  assign o_exc_cause      = exc_cause_reg;
  assign o_exc_addr       = exc_addr_reg;

endmodule

// File: tb/tb_core_lsu.sv
// Scoreboard bench for core_lsu: expected bus/writeback/fault events are queued at issue time
// and matched, including the cycle they must appear in, as the DUT produces them.
module tb_core_lsu;

  localparam int TO   = 4;
  localparam int K_RD = 0;
  localparam int K_WR = 1;
  localparam int K_WB = 2;
  localparam int K_EX = 3;

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
  } exp_t;

  logic        i_clk = 1'b0, i_rst_n = 1'b0, i_clk_en = 1'b1;
  logic        i_valid = 1'b0, i_is_load = 1'b0, i_is_store = 1'b0;
  logic [2:0]  i_funct3 = '0;
  logic [31:0] i_base = '0, i_offset = '0, i_store_data = '0;
  logic [4:0]  i_rd = '0;
  logic [31:0] i_mem_read_data = '0;
  logic        i_mem_ack = 1'b0;
  logic        o_busy, o_mem_read, o_mem_write, o_wb_valid, o_exc;
  logic [31:0] o_mem_read_addr, o_mem_write_addr, o_mem_write_data, o_wb_data, o_exc_addr;
  logic [3:0]  o_mem_byte_en;
  logic [4:0]  o_wb_rd;
  logic [2:0]  o_exc_cause;

  core_lsu #(.AW(32), .DW(32), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clk_en(i_clk_en), .i_valid(i_valid),
    .i_is_load(i_is_load), .i_is_store(i_is_store), .i_funct3(i_funct3),
    .i_base(i_base), .i_offset(i_offset), .i_store_data(i_store_data), .i_rd(i_rd),
    .o_busy(o_busy), .o_mem_read(o_mem_read), .o_mem_read_addr(o_mem_read_addr),
    .i_mem_read_data(i_mem_read_data), .i_mem_ack(i_mem_ack),
    .o_mem_write(o_mem_write), .o_mem_write_addr(o_mem_write_addr),
    .o_mem_byte_en(o_mem_byte_en), .o_mem_write_data(o_mem_write_data),
    .o_wb_valid(o_wb_valid), .o_wb_rd(o_wb_rd), .o_wb_data(o_wb_data),
    .o_exc(o_exc), .o_exc_cause(o_exc_cause), .o_exc_addr(o_exc_addr)
  );

  always #5 i_clk = ~i_clk;

  int   total = 0, bad = 0, cyc = 0, rd_hi_cnt = 0, ack_dly = 0, req_age = 0;
  bit   last_edge_en = 1'b0, prev_read = 1'b0, stray_ack = 1'b0;
  exp_t exp_q[$];
  logic [31:0] mem [logic [31:0]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [31:0] ea,
                                           input logic [2:0] f3, input logic [4:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    case (ea[1:0])
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = ea[1] ? w[31:16] : w[15:0];
    if (rd == 5'd0) return 32'h0;
    case (f3)
      3'd0:    return {{24{b[7]}}, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd4:    return {24'h0, b};
      3'd5:    return {16'h0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] ea);
    if (f3 == 3'd0) begin
      case (ea[1:0])
        2'd0:    return 4'b0001;
        2'd1:    return 4'b0010;
        2'd2:    return 4'b0100;
        default: return 4'b1000;
      endcase
    end
    if (f3 == 3'd1) return ea[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] exp_sd(input logic [2:0] f3, input logic [31:0] sd);
    if (f3 == 3'd0) return {4{sd[7:0]}};
    if (f3 == 3'd1) return {2{sd[15:0]}};
    return sd;
  endfunction

  task automatic push(input int kind, input int c, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] d);
    exp_t e;
    e.kind = kind; e.cyc = c; e.a = a; e.b = b; e.c = d;
    exp_q.push_back(e);
  endtask

  task automatic take(input int kind, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] d);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_event_kind", kind, 32'hFFFF_FFFF);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_cycle", cyc, e.cyc);
      chk("event_a", a, e.a);
      chk("event_b", b, e.b);
      chk("event_c", d, e.c);
      $display("txn kind=%0d cyc=%0d a=%h b=%h c=%h", kind, cyc, a, b, d);
    end
  endtask

  // Drives one instruction once the unit is idle and queues the events it must produce.
  task automatic issue(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] base,
                       input logic [31:0] off, input logic [31:0] sd, input logic [4:0] rd,
                       input int dly, input int extra, input bit done);
    int          n = 0;
    int          acc;
    logic [31:0] ea, wa;
    bit          ill, mis;
    @(negedge i_clk);
    while (o_busy && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    if (o_busy) chk("busy_stuck", {31'h0, o_busy}, 32'h0);
    ack_dly      = dly;
    i_valid      = 1'b1;
    i_is_load    = ld;
    i_is_store   = st;
    i_funct3     = f3;
    i_base       = base;
    i_offset     = off;
    i_store_data = sd;
    i_rd         = rd;
    @(posedge i_clk);
    #1;
    acc        = cyc;
    i_valid    = 1'b0;
    i_is_load  = 1'b0;
    i_is_store = 1'b0;
    ea  = base + off;
    wa  = {ea[31:2], 2'b00};
    ill = (ld && st) || (ld && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) ||
          (st && !(f3 inside {3'd0, 3'd1, 3'd2}));
    mis = ((f3[1:0] == 2'd1) && ea[0]) || ((f3[1:0] == 2'd2) && (ea[1:0] != 2'd0));
    if (ill) push(K_EX, acc, 32'd3, ea, 32'h0);
    else if (mis) push(K_EX, acc, ld ? 32'd1 : 32'd2, ea, 32'h0);
    else if (ld) begin
      push(K_RD, acc, wa, 32'h0, 32'h0);
      if (done) begin
        if (dly < TO) push(K_WB, acc + dly + 1 + extra, {27'h0, rd}, exp_load(rd_mem(wa), ea, f3, rd), 32'h0);
        else          push(K_EX, acc + TO + extra, 32'd4, ea, 32'h0);
      end
    end else push(K_WR, acc, wa, {28'h0, exp_be(f3, ea)}, exp_sd(f3, sd));
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge i_clk);
      if (exp_q.size() == 0 && !o_busy) ok = 1'b1;
    end
    if (!ok) chk("drain_pending", exp_q.size(), 32'h0);
  endtask

  initial begin
    fork
      forever begin
        @(posedge i_clk);
        cyc++;
        last_edge_en = i_clk_en && i_rst_n;
      end
      forever begin
        @(negedge i_clk);
        // Memory responder: acks after ack_dly enabled request cycles.
        if (o_mem_read) begin
          i_mem_ack       = (req_age == ack_dly) || stray_ack;
          i_mem_read_data = (req_age == ack_dly) ? rd_mem(o_mem_read_addr) : $urandom;
          if (last_edge_en) req_age++;
        end else begin
          req_age         = 0;
          i_mem_ack       = stray_ack;
          i_mem_read_data = $urandom;
        end
        if (last_edge_en) begin
          if (o_mem_read && !prev_read) take(K_RD, o_mem_read_addr, 32'h0, 32'h0);
          if (o_mem_read) rd_hi_cnt++;
          if (o_mem_write) take(K_WR, o_mem_write_addr, {28'h0, o_mem_byte_en}, o_mem_write_data);
          if (o_wb_valid) take(K_WB, {27'h0, o_wb_rd}, o_wb_data, 32'h0);
          if (o_exc) take(K_EX, {29'h0, o_exc_cause}, o_exc_addr, 32'h0);
        end
        prev_read = o_mem_read;
      end
      begin
        #2_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
      end
    join_none

    // Reset state
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_ctrl", {27'h0, o_busy, o_mem_read, o_mem_write, o_wb_valid, o_exc}, 32'h0);
    chk("rst_raddr", o_mem_read_addr, 32'h0);
    chk("rst_wr", {o_mem_write_addr[27:0], o_mem_byte_en} | o_mem_write_data, 32'h0);
    chk("rst_wb", o_wb_data | {27'h0, o_wb_rd}, 32'h0);
    chk("rst_exc", o_exc_addr | {29'h0, o_exc_cause}, 32'h0);
    i_rst_n = 1'b1;

    // Byte loads with a one-cycle-late ack
    mem[32'h100] = 32'h80FF_1234;
    issue(1, 0, 3'd0, 32'h100, 32'd3, 32'h0, 5'd5, 1, 0, 1);
    wait_idle();
    issue(1, 0, 3'd4, 32'h100, 32'd3, 32'h0, 5'd6, 1, 0, 1);
    wait_idle();

    // Halfword store: one write strobe, busy for exactly one cycle
    issue(0, 1, 3'd1, 32'h202, 32'd0, 32'h0000_ABCD, 5'd0, 0, 0, 1);
    @(negedge i_clk);
    chk("sh_busy_first", {31'h0, o_busy}, 32'h1);
    @(negedge i_clk);
    chk("sh_busy_after", {31'h0, o_busy}, 32'h0);
    wait_idle();

    // Misaligned word load and illegal store width
    issue(1, 0, 3'd2, 32'h100, 32'd2, 32'h0, 5'd1, 0, 0, 1);
    issue(0, 1, 3'd3, 32'h300, 32'd4, 32'h5555_AAAA, 5'd0, 0, 0, 1);
    wait_idle();

    // Bus timeout, then an ack in the last allowed cycle
    rd_hi_cnt = 0;
    issue(1, 0, 3'd2, 32'h400, 32'd0, 32'h0, 5'd7, 99, 0, 1);
    wait_idle();
    chk("timeout_read_cycles", rd_hi_cnt, 32'd4);
    rd_hi_cnt = 0;
    issue(1, 0, 3'd2, 32'h404, 32'd0, 32'h0, 5'd8, TO - 1, 0, 1);
    wait_idle();
    chk("late_ack_read_cycles", rd_hi_cnt, 32'd4);

    // Reset in the middle of a load, stray ack afterwards
    issue(1, 0, 3'd2, 32'h500, 32'd0, 32'h0, 5'd9, 99, 0, 0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    @(posedge i_clk);
    #1;
    i_rst_n   = 1'b1;
    stray_ack = 1'b1;
    @(negedge i_clk);
    chk("midrst_ctrl", {27'h0, o_busy, o_mem_read, o_mem_write, o_wb_valid, o_exc}, 32'h0);
    chk("midrst_raddr", o_mem_read_addr, 32'h0);
    @(posedge i_clk);
    #1;
    stray_ack = 1'b0;
    @(negedge i_clk);
    chk("stray_ack_ignored", {30'h0, o_busy, o_wb_valid}, 32'h0);
    issue(1, 0, 3'd1, 32'h100, 32'd2, 32'h0, 5'd10, 0, 0, 1);
    wait_idle();

    // Clock enable low for three cycles mid-request; address wraps
    rd_hi_cnt = 0;
    issue(1, 0, 3'd2, 32'hFFFF_FFFC, 32'd8, 32'h0, 5'd11, 99, 3, 1);
    @(negedge i_clk);
    @(negedge i_clk);
    i_clk_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      chk("frozen_read", {31'h0, o_mem_read}, 32'h1);
      chk("frozen_raddr", o_mem_read_addr, 32'h4);
    end
    i_clk_en = 1'b1;
    wait_idle();
    chk("frozen_read_cycles", rd_hi_cnt, 32'd4);

    // More lane/extension cases, back-to-back
    issue(1, 0, 3'd5, 32'h100, 32'd2, 32'h0, 5'd12, 0, 0, 1);
    issue(1, 0, 3'd2, 32'h100, 32'd0, 32'h0, 5'd0, 2, 0, 1);
    issue(0, 1, 3'd0, 32'h100, 32'd3, 32'h1234_5678, 5'd0, 0, 0, 1);
    issue(0, 1, 3'd2, 32'h0F0, 32'h10, 32'hDEAD_BEEF, 5'd0, 0, 0, 1);
    issue(0, 1, 3'd1, 32'h201, 32'd0, 32'h0000_1111, 5'd0, 0, 0, 1);
    wait_idle();

    // Random mix, issued as fast as the unit accepts
    for (int k = 0; k < 40; k++) begin
      int r;
      r = $urandom_range(0, 7);
      issue((r < 4) || (r == 7), r >= 4, 3'($urandom_range(0, 7)), $urandom & 32'hFFFF_FFFC,
            32'($urandom_range(0, 15)), $urandom, 5'($urandom_range(0, 31)),
            $urandom_range(0, 5), 0, 1);
    end
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
